// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: six hand registers, deck counter, hand scores,
// collision flag and saturating win/tie tallies for the round state machine.
module baccarat_datapath #(
    parameter int unsigned TALLY_W = 4
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               use_ext_card,
    input  logic [3:0]         card_in,
    input  logic               load_pcard1,
    input  logic               load_pcard2,
    input  logic               load_pcard3,
    input  logic               load_dcard1,
    input  logic               load_dcard2,
    input  logic               load_dcard3,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic [3:0]         pcard1,
    output logic [3:0]         pcard2,
    output logic [3:0]         pcard3,
    output logic [3:0]         dcard1,
    output logic [3:0]         dcard2,
    output logic [3:0]         dcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic [3:0]         next_card,
    output logic               load_err,
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally
);

    localparam int unsigned SLOT_N   = 6;
    localparam logic [3:0]  DECK_TOP = 4'd13;

    logic [3:0]        deck;
    logic [SLOT_N-1:0] ld_req;
    logic [SLOT_N-1:0] ld_gnt;
    logic              ld_multi;
    logic              pwin_q;
    logic              dwin_q;
    logic              round_done;

    // Baccarat value of one card: 1..9 at face, everything else counts 0.
    function automatic logic [4:0] card_val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    // Sum of three card values reduced mod 10 (sum never exceeds 27).
    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = card_val(a) + card_val(b) + card_val(c);
        if (s >= 5'd20)      s = s - 5'd20;
        else if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

    // Card source; an empty (post-reset) deck presents card 1.
    always_comb begin
        next_card = (deck == 4'd0) ? 4'd1 : deck;
        if (use_ext_card) next_card = card_in;
    end

    // Strobe vector in priority order (bit 0 wins) and one-hot grant.
    always_comb begin
        ld_req   = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
        ld_gnt   = ld_req & (~ld_req + SLOT_N'(1));
        ld_multi = (ld_req & (ld_req - SLOT_N'(1))) != '0;
    end

    // Hand scores follow the card registers directly.
    always_comb begin
        pscore = hand_score(pcard1, pcard2, pcard3);
        dscore = hand_score(dcard1, dcard2, dcard3);
    end

    // A round completes when either light first turns on.
    always_comb begin
        round_done = (player_win_light | dealer_win_light) & ~(pwin_q | dwin_q);
    end

    // Free-running deck counter cycling 1..13.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            deck <= 4'd0;
        end else if (deck == 4'd0 || deck >= DECK_TOP) begin
            deck <= 4'd1;
        end else begin
            deck <= deck + 4'd1;
        end
    end

    // Card slot registers and sticky collision flag.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            pcard1   <= 4'd0;
            pcard2   <= 4'd0;
            pcard3   <= 4'd0;
            dcard1   <= 4'd0;
            dcard2   <= 4'd0;
            dcard3   <= 4'd0;
            load_err <= 1'b0;
        end else begin
            if (ld_gnt[0]) pcard1 <= next_card;
            if (ld_gnt[1]) dcard1 <= next_card;
            if (ld_gnt[2]) pcard2 <= next_card;
            if (ld_gnt[3]) dcard2 <= next_card;
            if (ld_gnt[4]) pcard3 <= next_card;
            if (ld_gnt[5]) dcard3 <= next_card;
            if (ld_multi)  load_err <= 1'b1;
        end
    end

    // Light edge detect and saturating round tallies.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            pwin_q       <= 1'b0;
            dwin_q       <= 1'b0;
            player_tally <= '0;
            dealer_tally <= '0;
            tie_tally    <= '0;
        end else begin
            pwin_q <= player_win_light;
            dwin_q <= dealer_win_light;
            if (round_done) begin
                if (player_win_light && dealer_win_light) begin
                    if (tie_tally != '1) tie_tally <= tie_tally + TALLY_W'(1);
                end else if (player_win_light) begin
                    if (player_tally != '1) player_tally <= player_tally + TALLY_W'(1);
                end else begin
                    if (dealer_tally != '1) dealer_tally <= dealer_tally + TALLY_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: table-driven deal/collision vectors through a
// scoreboard queue, plus directed reset, deck-wrap and tally sequences.
module tb_baccarat_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b1;
    logic       use_ext_card = 1'b0;
    logic [3:0] card_in = 4'd0;
    logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic       player_win_light = 1'b0, dealer_win_light = 1'b0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, next_card;
    logic       load_err;
    logic [3:0] player_tally, dealer_tally, tie_tally;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [5:0] ld;    // bit order: p1,d1,p2,d2,p3,d3 (bit 0 = p1)
        logic [3:0] card;
        logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    logic [3:0] nc_q[$];

    baccarat_datapath #(.TALLY_W(4)) dut (
        .slow_clock(slow_clock), .resetb(resetb),
        .use_ext_card(use_ext_card), .card_in(card_in),
        .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
        .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
        .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
        .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
        .pscore(pscore), .dscore(dscore), .next_card(next_card),
        .load_err(load_err),
        .player_tally(player_tally), .dealer_tally(dealer_tally), .tie_tally(tie_tally)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic drive_loads(input logic [5:0] l);
        load_pcard1 = l[0]; load_dcard1 = l[1]; load_pcard2 = l[2];
        load_dcard2 = l[3]; load_pcard3 = l[4]; load_dcard3 = l[5];
    endtask

    task automatic add(input logic [5:0] l, input logic [3:0] c,
                       input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3,
                       input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                       input logic [3:0] ps, input logic [3:0] ds, input logic e);
        vec_t v;
        v.ld = l; v.card = c;
        v.p1 = p1; v.p2 = p2; v.p3 = p3; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.ps = ps; v.ds = ds; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic lights(input logic p, input logic d, input int n);
        player_win_light = p;
        dealer_win_light = d;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, " pcard1"}, pcard1, 4'd0);
        chk({tag, " pcard2"}, pcard2, 4'd0);
        chk({tag, " pcard3"}, pcard3, 4'd0);
        chk({tag, " dcard1"}, dcard1, 4'd0);
        chk({tag, " dcard2"}, dcard2, 4'd0);
        chk({tag, " dcard3"}, dcard3, 4'd0);
        chk({tag, " pscore"}, pscore, 4'd0);
        chk({tag, " dscore"}, dscore, 4'd0);
        chk({tag, " next_card"}, next_card, 4'd1);
        chk({tag, " load_err"}, 4'(load_err), 4'd0);
        chk({tag, " player_tally"}, player_tally, 4'd0);
        chk({tag, " dealer_tally"}, dealer_tally, 4'd0);
        chk({tag, " tie_tally"}, tie_tally, 4'd0);
    endtask

    initial begin
        vec_t e;
        logic [3:0] cur;
        logic [3:0] nxt;

        // Power-up reset state.
        #2;
        chk_all_clear("reset");
        @(negedge slow_clock);
        resetb = 1'b0;

        // Directed deal, overwrite, illegal card and collision priorities.
        //   ld         card   p1     p2     p3     d1      d2     d3     ps     ds     err
        add(6'b000001, 4'd9,  4'd9, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd9, 4'd0, 1'b0);
        add(6'b000010, 4'd13, 4'd9, 4'd0, 4'd0, 4'd13, 4'd0, 4'd0, 4'd9, 4'd0, 1'b0);
        add(6'b000100, 4'd5,  4'd9, 4'd5, 4'd0, 4'd13, 4'd0, 4'd0, 4'd4, 4'd0, 1'b0);
        add(6'b001000, 4'd4,  4'd9, 4'd5, 4'd0, 4'd13, 4'd4, 4'd0, 4'd4, 4'd4, 1'b0);
        add(6'b010000, 4'd8,  4'd9, 4'd5, 4'd8, 4'd13, 4'd4, 4'd0, 4'd2, 4'd4, 1'b0);
        add(6'b100000, 4'd1,  4'd9, 4'd5, 4'd8, 4'd13, 4'd4, 4'd1, 4'd2, 4'd5, 1'b0);
        add(6'b000001, 4'd3,  4'd3, 4'd5, 4'd8, 4'd13, 4'd4, 4'd1, 4'd6, 4'd5, 1'b0);
        add(6'b000010, 4'd15, 4'd3, 4'd5, 4'd8, 4'd15, 4'd4, 4'd1, 4'd6, 4'd5, 1'b0);
        add(6'b100100, 4'd7,  4'd3, 4'd7, 4'd8, 4'd15, 4'd4, 4'd1, 4'd8, 4'd5, 1'b1);
        add(6'b000011, 4'd2,  4'd2, 4'd7, 4'd8, 4'd15, 4'd4, 4'd1, 4'd7, 4'd5, 1'b1);
        add(6'b000110, 4'd6,  4'd2, 4'd7, 4'd8, 4'd6,  4'd4, 4'd1, 4'd7, 4'd1, 1'b1);
        add(6'b011000, 4'd9,  4'd2, 4'd7, 4'd8, 4'd6,  4'd9, 4'd1, 4'd7, 4'd6, 1'b1);
        add(6'b110000, 4'd2,  4'd2, 4'd7, 4'd2, 4'd6,  4'd9, 4'd1, 4'd1, 4'd6, 1'b1);
        for (int k = 0; k < 5; k++)
            add(6'b000000, 4'd0, 4'd2, 4'd7, 4'd2, 4'd6, 4'd9, 4'd1, 4'd1, 4'd6, 1'b1);

        use_ext_card = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive_loads(tbl[i].ld);
            card_in = tbl[i].card;
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d pcard1", i), pcard1, e.p1);
            chk($sformatf("v%0d pcard2", i), pcard2, e.p2);
            chk($sformatf("v%0d pcard3", i), pcard3, e.p3);
            chk($sformatf("v%0d dcard1", i), dcard1, e.d1);
            chk($sformatf("v%0d dcard2", i), dcard2, e.d2);
            chk($sformatf("v%0d dcard3", i), dcard3, e.d3);
            chk($sformatf("v%0d pscore", i), pscore, e.ps);
            chk($sformatf("v%0d dscore", i), dscore, e.ds);
            chk($sformatf("v%0d load_err", i), 4'(load_err), 4'(e.err));
        end
        drive_loads(6'b000000);
        use_ext_card = 1'b0;

        // Asynchronous reset between edges, then deck restarts at 1.
        #3;
        resetb = 1'b1;
        #1;
        chk_all_clear("midreset");
        @(negedge slow_clock);
        resetb = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("deck after edge %0d", k), next_card, 4'(k));
        end

        // Deck wrap 13 -> 1, loading pcard1 when 13 is offered.
        cur = 4'd3;
        for (int i = 0; i < 14; i++) begin
            nxt = (cur == 4'd13) ? 4'd1 : cur + 4'd1;
            load_pcard1 = (cur == 4'd13);
            nc_q.push_back(nxt);
            tick();
            load_pcard1 = 1'b0;
            chk($sformatf("wrap next_card %0d", i), next_card, nc_q.pop_front());
            if (cur == 4'd13) begin
                chk("wrap pcard1", pcard1, 4'd13);
                chk("wrap pscore", pscore, 4'd0);
            end
            cur = nxt;
        end

        // Tallies: player, tie held three cycles, dealer, then saturation.
        lights(1'b1, 1'b0, 1);
        lights(1'b0, 1'b0, 1);
        chk("tally player", player_tally, 4'd1);
        lights(1'b1, 1'b1, 1);
        chk("tally tie rise", tie_tally, 4'd1);
        lights(1'b1, 1'b1, 2);
        chk("tally tie held", tie_tally, 4'd1);
        chk("tally player held", player_tally, 4'd1);
        lights(1'b0, 1'b0, 1);
        lights(1'b0, 1'b1, 1);
        lights(1'b0, 1'b0, 1);
        chk("tally dealer", dealer_tally, 4'd1);
        chk("tally tie final", tie_tally, 4'd1);
        chk("tally player final", player_tally, 4'd1);
        for (int k = 0; k < 20; k++) begin
            lights(1'b1, 1'b0, 1);
            lights(1'b0, 1'b0, 1);
        end
        chk("tally player sat", player_tally, 4'd15);
        chk("tally dealer after sat", dealer_tally, 4'd1);
        chk("tally tie after sat", tie_tally, 4'd1);

        // Reset clears tallies without a clock edge.
        #2;
        resetb = 1'b1;
        #1;
        chk("reset player_tally", player_tally, 4'd0);
        chk("reset dealer_tally", dealer_tally, 4'd0);
        chk("reset tie_tally", tie_tally, 4'd0);
        @(negedge slow_clock);
        resetb = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
